// File: rtl/dma_rd_scheduler.sv
// Multi-channel DMA read scheduler: splits each channel transfer into bursts that
// never cross a 4 KB page and hands them to a read engine one at a time, round-robin.
module dma_rd_scheduler #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 8,
  parameter int NUM_CH     = 4,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_CH-1:0]                 ch_start,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]      ch_addr,
  input  logic [NUM_CH*LEN_WIDTH-1:0]       ch_len,
  output logic [NUM_CH-1:0]                 ch_busy,
  output logic [NUM_CH-1:0]                 ch_done,
  output logic                              cmd_valid,
  input  logic                              cmd_ready,
  output logic [ADDR_WIDTH-1:0]             cmd_addr,
  output logic [$clog2(BURST_LEN):0]        cmd_beats,
  output logic [$clog2(NUM_CH)-1:0]         cmd_ch,
  input  logic                              burst_done
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int BW    = $clog2(BURST_LEN) + 1;
  localparam int CHW   = $clog2(NUM_CH);
  localparam int MW    = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, UPDATE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q [NUM_CH];
  logic [LEN_WIDTH-1:0]  rem_q  [NUM_CH];
  logic [CHW-1:0]        rr_ptr;

  logic [CHW-1:0]        win;
  logic [CHW-1:0]        cand;
  logic                  win_found;
  int                    idx;
  logic [12:0]           page_bytes;
  logic [MW:0]           page_beats;
  logic [MW:0]           rem_ext;
  logic [MW:0]           lim;
  logic [BW-1:0]         beats_d;

  // Round-robin search starts at the channel after the last grant.
  always_comb begin
    win       = rr_ptr;
    win_found = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cand = CHW'(idx);
      if (!win_found && ch_busy[cand]) begin
        win       = cand;
        win_found = 1'b1;
      end
    end
  end

  // Burst size is the smallest of remaining beats, BURST_LEN and beats left in the page.
  always_comb begin
    page_bytes = 13'h1000 - {1'b0, addr_q[win][11:0]};
    page_beats = (MW+1)'(page_bytes >> OFF);
    rem_ext    = (MW+1)'(rem_q[win]);
    lim        = (MW+1)'(BURST_LEN);
    if (rem_ext < lim)    lim = rem_ext;
    if (page_beats < lim) lim = page_beats;
    beats_d    = BW'(lim);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found)  state_d = ISSUE;
      ISSUE:   if (cmd_ready)  state_d = WAIT;
      WAIT:    if (burst_done) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_valid <= 1'b0;
      cmd_addr  <= '0;
      cmd_beats <= '0;
      cmd_ch    <= '0;
      rr_ptr    <= '0;
    end else begin
      if (state_q == IDLE && win_found) begin
        cmd_valid <= 1'b1;
        cmd_addr  <= addr_q[win];
        cmd_beats <= beats_d;
        cmd_ch    <= win;
        rr_ptr    <= (win == CHW'(NUM_CH - 1)) ? '0 : win + 1'b1;
      end else if (state_q == ISSUE && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
    end
  end

  // A channel in UPDATE is still busy, so a same-cycle start on it is ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch_busy <= '0;
      ch_done <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        addr_q[i] <= '0;
        rem_q[i]  <= '0;
      end
    end else begin
      ch_done <= '0;
      if (state_q == UPDATE) begin
        addr_q[cmd_ch] <= addr_q[cmd_ch] + (ADDR_WIDTH'(cmd_beats) << OFF);
        rem_q[cmd_ch]  <= rem_q[cmd_ch] - LEN_WIDTH'(cmd_beats);
        if (rem_q[cmd_ch] == LEN_WIDTH'(cmd_beats)) begin
          ch_busy[cmd_ch] <= 1'b0;
          ch_done[cmd_ch] <= 1'b1;
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_start[i] && !ch_busy[i]) begin
          if (ch_len[i*LEN_WIDTH +: LEN_WIDTH] == '0) begin
            ch_done[i] <= 1'b1;
          end else begin
            addr_q[i]  <= ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            rem_q[i]   <= ch_len[i*LEN_WIDTH +: LEN_WIDTH];
            ch_busy[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_rd_scheduler.sv
// Directed bench for dma_rd_scheduler: table of single-channel transfers plus
// hand-written sequences for arbitration, zero length, back-pressure and reset.
module tb_dma_rd_scheduler;

  logic          clk;
  logic          reset_n;
  logic [3:0]    ch_start;
  logic [127:0]  ch_addr;
  logic [63:0]   ch_len;
  logic [3:0]    ch_busy;
  logic [3:0]    ch_done;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [31:0]   cmd_addr;
  logic [3:0]    cmd_beats;
  logic [1:0]    cmd_ch;
  logic          burst_done;

  int tests;
  int fails;

  dma_rd_scheduler #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_LEN(8), .NUM_CH(4), .LEN_WIDTH(16)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .ch_start(ch_start), .ch_addr(ch_addr), .ch_len(ch_len),
    .ch_busy(ch_busy), .ch_done(ch_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_beats(cmd_beats), .cmd_ch(cmd_ch),
    .burst_done(burst_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]        ch;
    logic [31:0]       addr;
    logic [15:0]       len;
    logic [1:0]        n;
    logic [2:0][31:0]  ea;
    logic [2:0][3:0]   eb;
  } vec_t;

  vec_t vecs [5];

  function automatic vec_t mkVec(logic [1:0] ch, logic [31:0] addr, logic [15:0] len,
                                 logic [1:0] n, logic [31:0] a0, logic [3:0] b0,
                                 logic [31:0] a1, logic [3:0] b1,
                                 logic [31:0] a2, logic [3:0] b2);
    vec_t v;
    v.ch = ch; v.addr = addr; v.len = len; v.n = n;
    v.ea[0] = a0; v.eb[0] = b0;
    v.ea[1] = a1; v.eb[1] = b1;
    v.ea[2] = a2; v.eb[2] = b2;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic armChannel(input int ch, input logic [31:0] addr, input logic [15:0] len);
    ch_start[ch]          = 1'b1;
    ch_addr[ch*32 +: 32]  = addr;
    ch_len[ch*16 +: 16]   = len;
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    ch_start = '0;
  endtask

  task automatic waitValid(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cmd_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s_timeout: got cmd_valid=0 expected cmd_valid=1 within 50 cycles", name);
    end
  endtask

  task automatic serveBurst(input string name, input logic [31:0] ea, input logic [31:0] eb,
                            input logic [31:0] ec, input logic [31:0] ed);
    bit ok;
    waitValid(name, ok);
    if (!ok) return;
    checkOutput({name, "_addr"}, cmd_addr, ea);
    checkOutput({name, "_beats"}, 32'(cmd_beats), eb);
    checkOutput({name, "_ch"}, 32'(cmd_ch), ec);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    checkOutput({name, "_valid_drop"}, 32'(cmd_valid), 32'd0);
    @(negedge clk);
    burst_done = 1'b1;
    @(negedge clk);
    burst_done = 1'b0;
    @(negedge clk);
    checkOutput({name, "_done"}, 32'(ch_done), ed);
  endtask

  initial begin
    bit ok;
    tests = 0;
    fails = 0;
    ch_start = '0; ch_addr = '0; ch_len = '0;
    cmd_ready = 1'b0; burst_done = 1'b0;
    reset_n = 1'b1;

    vecs[0] = mkVec(2'd0, 32'h1000, 16'd20, 2'd3, 32'h1000, 4'd8, 32'h1020, 4'd8, 32'h1040, 4'd4);
    vecs[1] = mkVec(2'd1, 32'h0FF8, 16'd8,  2'd2, 32'h0FF8, 4'd2, 32'h1000, 4'd6, 32'h0,    4'd0);
    vecs[2] = mkVec(2'd2, 32'h2FF0, 16'd3,  2'd1, 32'h2FF0, 4'd3, 32'h0,    4'd0, 32'h0,    4'd0);
    vecs[3] = mkVec(2'd3, 32'h0004, 16'd9,  2'd2, 32'h0004, 4'd8, 32'h0024, 4'd1, 32'h0,    4'd0);
    vecs[4] = mkVec(2'd1, 32'h1FFC, 16'd2,  2'd2, 32'h1FFC, 4'd1, 32'h2000, 4'd1, 32'h0,    4'd0);

    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", 32'(cmd_valid), 32'd0);
    checkOutput("rst_addr",  cmd_addr,       32'd0);
    checkOutput("rst_beats", 32'(cmd_beats), 32'd0);
    checkOutput("rst_busy",  32'(ch_busy),   32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_valid", 32'(cmd_valid), 32'd0);

    // Simultaneous starts right after reset: channel 0 must win first.
    armChannel(0, 32'h3000, 16'd16);
    armChannel(2, 32'h4000, 16'd16);
    applyStimulus();
    checkOutput("rr_busy", 32'(ch_busy), 32'b0101);
    serveBurst("rr_b0", 32'h3000, 32'd8, 32'd0, 32'b0000);
    serveBurst("rr_b1", 32'h4000, 32'd8, 32'd2, 32'b0000);
    serveBurst("rr_b2", 32'h3020, 32'd8, 32'd0, 32'b0001);
    serveBurst("rr_b3", 32'h4020, 32'd8, 32'd2, 32'b0100);
    @(negedge clk);
    checkOutput("rr_end_busy", 32'(ch_busy), 32'd0);

    for (int v = 0; v < 5; v++) begin
      armChannel(int'(vecs[v].ch), vecs[v].addr, vecs[v].len);
      applyStimulus();
      checkOutput($sformatf("vec%0d_busy", v), 32'(ch_busy), 32'(4'b0001 << vecs[v].ch));
      for (int k = 0; k < int'(vecs[v].n); k++) begin
        serveBurst($sformatf("vec%0d_b%0d", v, k), vecs[v].ea[k], 32'(vecs[v].eb[k]),
                   32'(vecs[v].ch),
                   (k == int'(vecs[v].n) - 1) ? 32'(4'b0001 << vecs[v].ch) : 32'd0);
      end
      @(negedge clk);
      checkOutput($sformatf("vec%0d_done_pulse", v), 32'(ch_done), 32'd0);
      checkOutput($sformatf("vec%0d_idle", v), 32'(ch_busy), 32'd0);
    end

    // Zero-length transfer completes without ever reaching the read engine.
    armChannel(3, 32'h8000, 16'd0);
    applyStimulus();
    checkOutput("len0_done", 32'(ch_done), 32'b1000);
    checkOutput("len0_busy", 32'(ch_busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("len0_novalid%0d", i), 32'(cmd_valid), 32'd0);
    end
    checkOutput("len0_pulse_end", 32'(ch_done), 32'd0);

    burst_done = 1'b1;
    @(negedge clk);
    burst_done = 1'b0;
    @(negedge clk);
    checkOutput("stray_idle_valid", 32'(cmd_valid), 32'd0);
    checkOutput("stray_idle_done",  32'(ch_done),   32'd0);

    // Back-pressure: command held while other channels start and a stray burst_done arrives.
    armChannel(1, 32'h5000, 16'd4);
    applyStimulus();
    waitValid("stall", ok);
    if (ok) begin
      for (int i = 0; i < 5; i++) begin
        checkOutput($sformatf("stall%0d_valid", i), 32'(cmd_valid), 32'd1);
        checkOutput($sformatf("stall%0d_addr", i),  cmd_addr,       32'h5000);
        checkOutput($sformatf("stall%0d_beats", i), 32'(cmd_beats), 32'd4);
        checkOutput($sformatf("stall%0d_ch", i),    32'(cmd_ch),    32'd1);
        ch_start   = '0;
        burst_done = 1'b0;
        if (i == 1) begin
          armChannel(1, 32'h9000, 16'd1);
          armChannel(3, 32'h6000, 16'd2);
        end
        if (i == 2) burst_done = 1'b1;
        @(negedge clk);
      end
      ch_start   = '0;
      burst_done = 1'b0;
      checkOutput("stall_busy", 32'(ch_busy), 32'b1010);
      serveBurst("stall_cmd", 32'h5000, 32'd4, 32'd1, 32'b0010);
      serveBurst("late_ch3",  32'h6000, 32'd2, 32'd3, 32'b1000);
      @(negedge clk);
      checkOutput("stall_end_busy", 32'(ch_busy), 32'd0);
    end

    // Reset while waiting for burst_done drops everything immediately.
    armChannel(0, 32'h7000, 16'd16);
    applyStimulus();
    waitValid("rst_wait", ok);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(cmd_valid), 32'd0);
    checkOutput("midrst_addr",  cmd_addr,       32'd0);
    checkOutput("midrst_beats", 32'(cmd_beats), 32'd0);
    checkOutput("midrst_ch",    32'(cmd_ch),    32'd0);
    checkOutput("midrst_busy",  32'(ch_busy),   32'd0);
    checkOutput("midrst_done",  32'(ch_done),   32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    burst_done = 1'b1;
    @(negedge clk);
    burst_done = 1'b0;
    @(negedge clk);
    checkOutput("after_rst_done",  32'(ch_done),   32'd0);
    checkOutput("after_rst_valid", 32'(cmd_valid), 32'd0);
    armChannel(0, 32'h2000, 16'd4);
    applyStimulus();
    serveBurst("after_rst", 32'h2000, 32'd4, 32'd0, 32'b0001);
    @(negedge clk);
    checkOutput("after_rst_pulse_end", 32'(ch_done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
